// File: rtl/sm_regdump_uart_if.sv
// Bundle between the register-dump UART and its surroundings: the host-side
// dump request/status, the sm_cpu debug read port and the serial line.
// slave  : the dump engine (drives address, line and status).
// master : the environment (drives start and returns register data).
interface sm_regdump_uart_if;
   logic        start;     // dump request, level-sampled while idle
   logic [4:0]  regAddr;   // debug read address towards sm_cpu
   logic [31:0] regData;   // debug read data, combinational from regAddr
   logic        uart_tx;   // 8N1 serial output, idle high
   logic        busy;      // frame in progress
   logic        done;      // one-cycle pulse at the end of a frame

   modport slave (
      input  start,
      input  regData,
      output regAddr,
      output uart_tx,
      output busy,
      output done
   );

   modport master (
      output start,
      output regData,
      input  regAddr,
      input  uart_tx,
      input  busy,
      input  done
   );
endinterface

// File: rtl/sm_regdump_uart.sv
// Register dump over UART for sm_cpu.
// On a start request the engine sends SYNC_BYTE, then walks regAddr from
// FIRST_REG to LAST_REG, capturing each 32-bit word once and sending it as
// four 8N1 bytes, most significant byte first. Bytes follow each other with
// no idle time on the line.
//
// Timing model: the baud and bit counters describe the bit that uart_tx will
// show one cycle later (uart_tx is a flop fed from the counters). The counters
// keep running through LATCH and LOADB: those states always fall inside the
// start bit of the next byte, which is a constant 0, so the word capture and
// byte load are hidden behind the start bit and no gap appears between bytes.
// This needs at least two cycles per bit (BAUD_DIV >= 2).
module sm_regdump_uart #(
   parameter int         BAUD_DIV  = 434,
   parameter int         FIRST_REG = 0,
   parameter int         LAST_REG  = 31,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic              clk,
   input logic              rst_n,
   sm_regdump_uart_if.slave bus
);

   localparam int             BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [4:0]     FIRST_A   = 5'(FIRST_REG);
   localparam logic [4:0]     LAST_A    = 5'(LAST_REG);
   localparam logic [3:0]     BIT_STOP  = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_LATCH,
      S_LOADB,
      S_SEND,
      S_DONE
   } state_t;

   state_t        state_q,    state_d;
   logic [4:0]    reg_addr_q, reg_addr_d;
   logic [31:0]   word_q,     word_d;
   logic [1:0]    idx_q,      idx_d;
   logic [7:0]    shift_q,    shift_d;
   logic [BW-1:0] baud_q,     baud_d;
   logic [3:0]    bit_q,      bit_d;
   logic          sync_q,     sync_d;
   logic          tx_q,       tx_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;

   logic          tx_run;
   logic          baud_tick;
   logic          byte_end;
   logic [2:0]    data_sel;

   // Next-state, counter and line computation for the dump engine.
   always_comb begin
      state_d    = state_q;
      reg_addr_d = reg_addr_q;
      word_d     = word_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      sync_d     = sync_q;
      tx_d       = 1'b1;
      busy_d     = busy_q;

      // The transmitter is live in every state that belongs to a byte.
      tx_run    = (state_q == S_SEND) || (state_q == S_LATCH) || (state_q == S_LOADB);
      baud_tick = (baud_q == BAUD_LAST);
      byte_end  = baud_tick && (bit_q == BIT_STOP);
      // Data bits occupy bit slots 1..8; slot 8 maps to shifter bit 7.
      data_sel  = bit_q[2:0] - 3'd1;

      // Baud counter wraps at BAUD_DIV-1, bit counter walks 0..9.
      if (tx_run) begin
         if (baud_tick) begin
            baud_d = '0;
            bit_d  = (bit_q == BIT_STOP) ? 4'd0 : bit_q + 4'd1;
         end else begin
            baud_d = baud_q + BW'(1);
         end
      end else begin
         baud_d = '0;
         bit_d  = 4'd0;
      end

      // Line level for the current bit slot: start 0, data LSB first, stop 1.
      if (tx_run) begin
         if (bit_q == 4'd0) begin
            tx_d = 1'b0;
         end else if (bit_q == BIT_STOP) begin
            tx_d = 1'b1;
         end else begin
            tx_d = shift_q[data_sel];
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_SYNC;
               busy_d     = 1'b1;
               reg_addr_d = FIRST_A;
            end
         end

         S_SYNC: begin
            shift_d = SYNC_BYTE;
            sync_d  = 1'b1;
            state_d = S_SEND;
         end

         S_LATCH: begin
            // regAddr was updated on the previous edge, so regData is settled.
            word_d  = bus.regData;
            idx_d   = 2'd3;
            state_d = S_LOADB;
         end

         S_LOADB: begin
            shift_d = word_q[{idx_q, 3'b000} +: 8];
            state_d = S_SEND;
         end

         S_SEND: begin
            if (byte_end) begin
               if (sync_q) begin
                  // Header sent; regAddr already points at FIRST_REG.
                  sync_d  = 1'b0;
                  state_d = S_LATCH;
               end else if (idx_q != 2'd0) begin
                  idx_d   = idx_q - 2'd1;
                  state_d = S_LOADB;
               end else if (reg_addr_q < LAST_A) begin
                  reg_addr_d = reg_addr_q + 5'd1;
                  state_d    = S_LATCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            busy_d     = 1'b0;
            reg_addr_d = FIRST_A;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // done is high exactly while the FSM sits in DONE.
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset drops the line high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         reg_addr_q <= FIRST_A;
         word_q     <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         sync_q     <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_addr_q <= reg_addr_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         sync_q     <= sync_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.regAddr = reg_addr_q;
   assign bus.uart_tx = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart with BAUD_DIV=4 and a two-register dump (0..1).
// Line, busy and done are logged once per cycle; frames are then decoded
// from the log and compared against hand-written byte strings.
// Cycle bookkeeping: log[N] holds the value seen after clock edge N; a start
// request is accepted on edge e, so the start bit is expected at log[e+2],
// the 9 bytes occupy 360 line cycles, busy spans e .. e+361 (362 cycles) and
// done is high in the final busy cycle e+361.
module tb_sm_regdump_uart;
   localparam int BD        = 4;
   localparam int FRAME_CYC = 9 * 10 * BD;
   localparam int BUSY_CYC  = 2 + FRAME_CYC;
   localparam int LOG_N     = 8192;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      bit          poke;    // pulse start again at busy cycle 100
      bit          chg;     // zero addr1 data at busy cycle 100
      logic [71:0] exp;     // expected frame, first byte in the top bits
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] d0;
   logic [31:0] d1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        tx_log   [LOG_N];
   logic        busy_log [LOG_N];
   logic        done_log [LOG_N];
   logic [7:0]  got [$];
   int          ferr;

   sm_regdump_uart_if bus ();

   sm_regdump_uart #(
      .BAUD_DIV  (BD),
      .FIRST_REG (0),
      .LAST_REG  (1),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // sm_cpu debug port model: data is a pure function of the address.
   assign bus.regData = (bus.regAddr == 5'd0) ? d0 :
                        (bus.regAddr == 5'd1) ? d1 : 32'hDEAD_BEEF;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         tx_log[cyc]   <= bus.uart_tx;
         busy_log[cyc] <= bus.busy;
         done_log[cyc] <= bus.done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Decode back-to-back 8N1 bytes from the line log, sampling mid-bit.
   task automatic decode(input int a, input int b);
      int         i;
      logic [7:0] v;
      got.delete();
      ferr = 0;
      i = a;
      while (i < b) begin
         if (tx_log[i] === 1'b0) begin
            for (int k = 0; k < 8; k++) v[k] = tx_log[i + BD * (k + 1) + BD / 2];
            if (tx_log[i + BD * 9 + BD / 2] !== 1'b1) ferr++;
            got.push_back(v);
            i += 10 * BD - 1;
         end else begin
            i++;
         end
      end
   endtask

   task automatic check_frame(input string tag, input int e, input logic [71:0] exp, input bit tail);
      int          fall;
      int          low;
      int          bsy;
      int          dcnt;
      int          dpos;
      int          tail_busy;
      logic [31:0] act;
      decode(e, e + BUSY_CYC + 1);
      chk({tag, " nbytes"}, 32'(got.size()), 32'd9);
      for (int k = 0; k < 9; k++) begin
         act = (k < got.size()) ? {24'd0, got[k]} : 32'h100;
         chk($sformatf("%s byte%0d", tag, k), act, {24'd0, exp[71 - 8 * k -: 8]});
      end
      chk({tag, " framing"}, 32'(ferr), 32'd0);
      fall = -1;
      for (int i = e; i < e + 20; i++) if (fall < 0 && tx_log[i] === 1'b0) fall = i;
      chk({tag, " start latency"}, 32'(fall - e), 32'd2);
      low = 0;
      if (fall >= 0) while (low < 50 && tx_log[fall + low] === 1'b0) low++;
      chk({tag, " start bit len"}, 32'(low), 32'(BD));
      chk({tag, " busy before"}, 32'(busy_log[e - 1]), 32'd0);
      bsy = 0;
      while (bsy < 1000 && busy_log[e + bsy] === 1'b1) bsy++;
      chk({tag, " busy len"}, 32'(bsy), 32'(BUSY_CYC));
      dcnt = 0;
      dpos = -1;
      for (int i = e; i < e + BUSY_CYC + 1; i++) begin
         if (done_log[i] === 1'b1) begin
            dcnt++;
            dpos = i - e;
         end
      end
      chk({tag, " done count"}, 32'(dcnt), 32'd1);
      chk({tag, " done pos"}, 32'(dpos), 32'(BUSY_CYC - 1));
      if (tail) begin
         tail_busy = 0;
         for (int i = e + BUSY_CYC; i < e + BUSY_CYC + 30; i++)
            if (busy_log[i] !== 1'b0 || done_log[i] !== 1'b0) tail_busy++;
         chk({tag, " idle after"}, 32'(tail_busy), 32'd0);
      end
   endtask

   initial begin
      vec_t vecs [5];
      int   e;
      int   dcnt;

      vecs[0] = '{32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0, 72'hA5_12345678_CAFEF00D};
      vecs[1] = '{32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0, 72'hA5_12345678_CAFEF00D};
      vecs[2] = '{32'h12345678, 32'hCAFEF00D, 1'b0, 1'b1, 72'hA5_12345678_00000000};
      vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 72'hA5_FFFFFFFF_00000001};
      vecs[4] = '{32'h80000000, 32'h5A0F3C96, 1'b0, 1'b0, 72'hA5_80000000_5A0F3C96};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      d0        = 32'h0;
      d1        = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset regAddr", 32'(bus.regAddr), 32'd0);
      chk("reset uart_tx", 32'(bus.uart_tx), 32'd1);
      chk("reset busy",    32'(bus.busy),    32'd0);
      chk("reset done",    32'(bus.done),    32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Table-driven single frames.
      for (int v = 0; v < 5; v++) begin
         d0 = vecs[v].d0;
         d1 = vecs[v].d1;
         @(negedge clk);
         bus.start = 1'b1;
         e = cyc + 1;
         @(negedge clk);
         bus.start = 1'b0;
         if (vecs[v].poke || vecs[v].chg) begin
            while (cyc < e + 100) @(negedge clk);
            if (vecs[v].poke) bus.start = 1'b1;
            if (vecs[v].chg)  d1 = 32'h0;
            @(negedge clk);
            bus.start = 1'b0;
         end
         while (cyc < e + BUSY_CYC + 40) @(negedge clk);
         check_frame($sformatf("vec%0d", v), e, vecs[v].exp, 1'b1);
      end

      // start held high: second frame accepted the cycle after DONE.
      d0 = 32'h12345678;
      d1 = 32'hCAFEF00D;
      @(negedge clk);
      bus.start = 1'b1;
      e = cyc + 1;
      while (cyc < e + BUSY_CYC + 40) @(negedge clk);
      bus.start = 1'b0;
      while (cyc < e + 2 * (BUSY_CYC + 1) + 40) @(negedge clk);
      check_frame("held1", e, 72'hA5_12345678_CAFEF00D, 1'b0);
      check_frame("held2", e + BUSY_CYC + 1, 72'hA5_12345678_CAFEF00D, 1'b1);

      // Reset in the middle of the third byte (0x34, during its bit 1 = 0).
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      e = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < e + 90) @(negedge clk);
      chk("pre-reset uart_tx", 32'(bus.uart_tx), 32'd0);
      chk("pre-reset busy",    32'(bus.busy),    32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid reset uart_tx", 32'(bus.uart_tx), 32'd1);
      chk("mid reset busy",    32'(bus.busy),    32'd0);
      chk("mid reset regAddr", 32'(bus.regAddr), 32'd0);
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      dcnt = 0;
      for (int i = e; i < cyc - 2; i++) if (done_log[i] !== 1'b0) dcnt++;
      chk("reset no done", 32'(dcnt), 32'd0);
      chk("post-reset uart_tx", 32'(bus.uart_tx), 32'd1);
      bus.start = 1'b1;
      e = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < e + BUSY_CYC + 40) @(negedge clk);
      check_frame("after reset", e, 72'hA5_12345678_CAFEF00D, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
